// File: rtl/aclk_key_pkg.sv
// Shared key codes, scanner state type and the row/column to key-code map
// for the alarm-clock keypad front end.
package aclk_key_pkg;

   localparam logic [3:0] KEY_NONE  = 4'hA;
   localparam logic [3:0] KEY_STAR  = 4'hB;
   localparam logic [3:0] KEY_HASH  = 4'hC;
   localparam logic [3:0] KEY_MULTI = 4'hF;

   typedef enum logic {
      SCAN = 1'b0,
      EVAL = 1'b1
   } scan_state_e;

   // Rows 0-2 hold consecutive digits; row 3 is '*', '0', '#'.
   function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
      logic [3:0] code;
      code = KEY_NONE;
      case (row)
         2'd0: code = 4'd1 + {2'b00, col};
         2'd1: code = 4'd4 + {2'b00, col};
         2'd2: code = 4'd7 + {2'b00, col};
         default: begin
            case (col)
               2'd0:    code = KEY_STAR;
               2'd1:    code = 4'd0;
               default: code = KEY_HASH;
            endcase
         end
      endcase
      return code;
   endfunction

endpackage

// File: rtl/aclk_key_debounce.sv
// Frame-level debouncer: commits a key state after DEBOUNCE_CNT identical
// frames and strobes key_valid once per newly committed digit.
module aclk_key_debounce
   import aclk_key_pkg::*;
#(
   parameter int DEBOUNCE_CNT = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] frame_code,
   input  logic       frame_done,
   output logic [3:0] key,
   output logic       alarm_button,
   output logic       time_button,
   output logic       key_valid
);

   localparam int CW = $clog2(DEBOUNCE_CNT + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CNT);

   logic [3:0]    cand_q, cand_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    comm_q;
   logic [3:0]    key_q;
   logic          alarm_q, time_q, valid_q;
   logic          commit;

   always_comb begin
      cand_d = cand_q;
      cnt_d  = cnt_q;
      if (frame_done) begin
         if (frame_code == KEY_MULTI) begin
            cnt_d = '0;
         end else if (frame_code != cand_q) begin
            cand_d = frame_code;
            cnt_d  = CW'(1);
         end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
         end
      end
      // A multi-key frame forces cnt_d to zero, so it can never commit.
      commit = frame_done && (cnt_d == CNT_MAX) && (cand_d != comm_q);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cand_q  <= KEY_NONE;
         cnt_q   <= CNT_MAX;
         comm_q  <= KEY_NONE;
         key_q   <= KEY_NONE;
         alarm_q <= 1'b0;
         time_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         cand_q  <= cand_d;
         cnt_q   <= cnt_d;
         valid_q <= commit && (cand_d < 4'd10);
         if (commit) begin
            comm_q  <= cand_d;
            key_q   <= (cand_d < 4'd10) ? cand_d : KEY_NONE;
            alarm_q <= (cand_d == KEY_STAR);
            time_q  <= (cand_d == KEY_HASH);
         end
      end
   end

   assign key          = key_q;
   assign alarm_button = alarm_q;
   assign time_button  = time_q;
   assign key_valid    = valid_q;

endmodule

// File: rtl/aclk_keypad_scan.sv
// 4x3 keypad scanner: drives rows one-hot low, synchronizes the column
// returns, reduces each full scan to a frame code and debounces it.
//
//   state | meaning
//   SCAN  | drive row row_q for SCAN_DIV cycles, sample columns on the last
//   EVAL  | one cycle: reduce the 12 sampled bits and hand the code to the debouncer
module aclk_keypad_scan
   import aclk_key_pkg::*;
#(
   parameter int SCAN_DIV     = 8,
   parameter int DEBOUNCE_CNT = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] col_n,
   output logic [3:0] row_n,
   output logic [3:0] key,
   output logic       alarm_button,
   output logic       time_button,
   output logic       key_valid
);

   localparam int DW = $clog2(SCAN_DIV);
   localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

   logic [2:0]       sync1_q, sync2_q;
   scan_state_e      state_q;
   logic [1:0]       row_q;
   logic [DW-1:0]    div_q;
   logic [3:0][2:0]  frame_q;
   logic [3:0]       row_n_q;

   logic [3:0]       frame_code;
   logic [3:0]       n_hits;
   logic [3:0]       hit_code;
   logic             frame_done;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= 3'b111;
         sync2_q <= 3'b111;
         state_q <= SCAN;
         row_q   <= 2'd0;
         div_q   <= '0;
         frame_q <= '0;
         row_n_q <= 4'b1110;
      end else begin
         sync1_q <= col_n;
         sync2_q <= sync1_q;
         case (state_q)
            SCAN: begin
               if (div_q == DIV_LAST) begin
                  div_q          <= '0;
                  frame_q[row_q] <= ~sync2_q;
                  if (row_q == 2'd3) begin
                     state_q <= EVAL;
                     row_q   <= 2'd0;
                     row_n_q <= 4'b1110;
                  end else begin
                     row_q   <= row_q + 2'd1;
                     row_n_q <= ~(4'b0001 << (row_q + 2'd1));
                  end
               end else begin
                  div_q <= div_q + DW'(1);
               end
            end
            EVAL: begin
               // Row 0 is already driven here, so its columns settle early.
               state_q <= SCAN;
            end
         endcase
      end
   end

   always_comb begin
      n_hits     = '0;
      hit_code   = KEY_NONE;
      frame_code = KEY_NONE;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 3; c++) begin
            if (frame_q[r][c]) begin
               n_hits   = n_hits + 4'd1;
               hit_code = key_map(2'(r), 2'(c));
            end
         end
      end
      if (n_hits == 4'd1) begin
         frame_code = hit_code;
      end else if (n_hits != 4'd0) begin
         frame_code = KEY_MULTI;
      end
   end

   assign frame_done = (state_q == EVAL);
   assign row_n      = row_n_q;

   aclk_key_debounce #(
      .DEBOUNCE_CNT (DEBOUNCE_CNT)
   ) u_debounce (
      .clk          (clk),
      .reset        (reset),
      .frame_code   (frame_code),
      .frame_done   (frame_done),
      .key          (key),
      .alarm_button (alarm_button),
      .time_button  (time_button),
      .key_valid    (key_valid)
   );

endmodule

// File: tb/tb_aclk_keypad_scan.sv
// Bench for aclk_keypad_scan: keypad model plus a frame-level reference of
// what each scan reads and how the debouncer must respond.
module tb_aclk_keypad_scan;

   localparam int SCAN_DIV     = 4;
   localparam int DEBOUNCE_CNT = 3;
   localparam int FRAME        = 4 * SCAN_DIV + 1;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [2:0] col_n;
   logic [3:0] row_n;
   logic [3:0] key;
   logic       alarm_button;
   logic       time_button;
   logic       key_valid;

   logic [11:0] pressed = '0;

   int checks = 0;
   int errors = 0;

   aclk_keypad_scan #(
      .SCAN_DIV     (SCAN_DIV),
      .DEBOUNCE_CNT (DEBOUNCE_CNT)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .col_n        (col_n),
      .row_n        (row_n),
      .key          (key),
      .alarm_button (alarm_button),
      .time_button  (time_button),
      .key_valid    (key_valid)
   );

   always #5 clk = ~clk;

   // Pressed key (r,c) pulls column c low while its row is driven.
   always_comb begin
      col_n = 3'b111;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 3; c++)
            if (pressed[r*3+c] && !row_n[r]) col_n[c] = 1'b0;
   end

   // Key legend in scan order (row-major); 11 = '*', 12 = '#'.
   int key_of [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 11, 0, 12};

   int          cyc;
   logic [11:0] snap;
   int          m_cand, m_cnt, m_comm;
   logic [3:0]  e_key;
   logic        e_alarm, e_time, e_valid;
   int          pulses;
   logic        seen_a;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int frame_of(input logic [11:0] s);
      int n;
      n = $countones(s);
      if (n == 0) return 10;
      if (n > 1) return 15;
      for (int i = 0; i < 12; i++)
         if (s[i]) return key_of[i];
      return 10;
   endfunction

   task automatic set_exp();
      e_key   = (m_comm < 10) ? 4'(m_comm) : 4'hA;
      e_alarm = (m_comm == 11);
      e_time  = (m_comm == 12);
   endtask

   task automatic model_reset();
      cyc     = 0;
      snap    = '0;
      m_cand  = 10;
      m_cnt   = DEBOUNCE_CNT;
      m_comm  = 10;
      e_valid = 1'b0;
      set_exp();
   endtask

   task automatic model_frame();
      int code;
      code = frame_of(snap);
      if (code == 15) m_cnt = 0;
      else if (code != m_cand) begin
         m_cand = code;
         m_cnt  = 1;
      end else if (m_cnt < DEBOUNCE_CNT) m_cnt++;
      if (code != 15 && m_cnt == DEBOUNCE_CNT && m_cand != m_comm) begin
         m_comm  = m_cand;
         e_valid = (m_comm < 10);
         set_exp();
      end
   endtask

   // One clock: the row read at the end of each row window reflects the keys
   // two cycles earlier (synchronizer); outputs move only after EVAL.
   task automatic step();
      int j, jr;
      logic [3:0] er;
      @(posedge clk);
      cyc++;
      j = (cyc - 1) % FRAME + 1;
      for (int r = 0; r < 4; r++)
         if (j == SCAN_DIV * r + SCAN_DIV - 2) snap[r*3 +: 3] = pressed[r*3 +: 3];
      e_valid = 1'b0;
      if (j == FRAME) model_frame();
      #1;
      jr = (j < 4 * SCAN_DIV) ? j / SCAN_DIV : 0;
      er = 4'b1111;
      er[jr] = 1'b0;
      check("row_n", row_n, er);
      check("key", key, e_key);
      check("alarm_button", alarm_button, e_alarm);
      check("time_button", time_button, e_time);
      check("key_valid", key_valid, e_valid);
      if (key_valid === 1'b1) pulses++;
      if (key === 4'hA) seen_a = 1'b1;
   endtask

   task automatic frames(input int n);
      repeat (n * FRAME) step();
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      #1;
      check("rst_row_n", row_n, 4'b1110);
      check("rst_key", key, 4'hA);
      check("rst_alarm", alarm_button, 1'b0);
      check("rst_time", time_button, 1'b0);
      check("rst_valid", key_valid, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      check("rst_hold_valid", key_valid, 1'b0);
      check("rst_hold_row_n", row_n, 4'b1110);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   function automatic logic [11:0] rand_pattern();
      logic [11:0] p;
      int sel;
      p   = '0;
      sel = $urandom_range(0, 3);
      if (sel == 0) p = '0;
      else if (sel < 3) p[$urandom_range(0, 11)] = 1'b1;
      else begin
         p[$urandom_range(0, 11)] = 1'b1;
         p[$urandom_range(0, 11)] = 1'b1;
      end
      return p;
   endfunction

   initial begin
      pulses = 0;
      seen_a = 1'b0;
      model_reset();
      apply_reset();

      // Clean press of '5' (r1,c1): committed at the end of frame 3 (51 cycles).
      pressed = 12'b1 << 4;
      pulses  = 0;
      frames(3);
      check("press5_latency", key, 4'h5);
      frames(7);
      check("press5_pulses", pulses, 1);
      pressed = '0;
      pulses  = 0;
      frames(3);
      check("release5_key", key, 4'hA);
      check("release5_pulses", pulses, 0);
      frames(2);

      // '7' bouncing every 10 cycles for five frames, then held.
      for (int k = 0; k < 5 * FRAME; k++) begin
         if (k % 10 == 0) pressed = pressed ^ (12'b1 << 6);
         step();
      end
      pressed = 12'b1 << 6;
      frames(3);
      check("bounce7_key", key, 4'h7);
      frames(1);
      pressed = '0;
      frames(4);

      // '1' and '2' together, then '2' released.
      pressed = 12'b11;
      pulses  = 0;
      frames(6);
      check("multi_key", key, 4'hA);
      check("multi_pulses", pulses, 0);
      pressed = 12'b1;
      frames(3);
      check("multi_then1_key", key, 4'h1);
      pressed = '0;
      frames(4);

      // '*' then '#': buttons swap on the same cycle, never strobe.
      pressed = 12'b1 << 9;
      pulses  = 0;
      frames(3);
      check("star_alarm", alarm_button, 1'b1);
      check("star_key", key, 4'hA);
      frames(1);
      pressed = 12'b1 << 11;
      frames(3);
      check("hash_alarm", alarm_button, 1'b0);
      check("hash_time", time_button, 1'b1);
      check("func_pulses", pulses, 0);
      frames(1);
      pressed = '0;
      frames(4);

      // '0' directly to '9'.
      pressed = 12'b1 << 10;
      frames(4);
      check("digit0_key", key, 4'h0);
      pressed = 12'b1 << 8;
      pulses  = 0;
      seen_a  = 1'b0;
      frames(4);
      check("digit9_key", key, 4'h9);
      check("digit9_pulses", pulses, 1);
      check("digit9_no_none", seen_a, 1'b0);
      pressed = '0;
      frames(4);

      // Reset mid-frame with '5' held.
      pressed = 12'b1 << 4;
      frames(4);
      repeat (7) step();
      apply_reset();
      frames(3);
      check("post_reset_key5", key, 4'h5);
      pressed = '0;
      frames(4);

      // Random key activity changing at arbitrary cycles.
      repeat (700) begin
         if ($urandom_range(0, 11) == 0) pressed = rand_pattern();
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
